// File: rtl/checker_stream_sched.sv
// rtl/checker_stream_sched.sv - arbitrates two trace-char sources onto one cpu_checker, reports tagged results
module checker_stream_sched #(
  parameter int          MAX_LEN = 64,
  parameter int          CNT_W   = 16,
  parameter logic [7:0]  FILL    = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       s0_char,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [7:0]       s1_char,
  input  logic             s1_valid,
  output logic             s1_ready,
  output logic [7:0]       chk_char,
  output logic             chk_reset,
  input  logic [1:0]       chk_format,
  output logic             res_valid,
  output logic             res_src,
  output logic [1:0]       res_type,
  output logic             res_abort,
  output logic [CNT_W-1:0] cnt_reg,
  output logic [CNT_W-1:0] cnt_mem,
  output logic [CNT_W-1:0] cnt_bad
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, REPORT} state_t;

  state_t           state, state_nx;
  logic             grant, grant_nx, rr;
  logic [LEN_W-1:0] len;
  logic             wait_ph;
  logic [1:0]       type_r;
  logic             abort_r;
  logic             start, xfer, do_abort;
  logic             cur_valid;
  logic [7:0]       cur_char;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    start     = 1'b0;
    xfer      = 1'b0;
    do_abort  = 1'b0;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    cur_valid = grant ? s1_valid : s0_valid;
    cur_char  = grant ? s1_char  : s0_char;
    case (state)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          start    = 1'b1;
          grant_nx = rr ? s1_valid : !s0_valid;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        s0_ready = !grant && s0_valid;
        s1_ready =  grant && s1_valid;
        if (cur_valid) begin
          xfer = 1'b1;
          if (cur_char == 8'h23) begin
            state_nx = WAIT;
          end else if (len == LEN_W'(MAX_LEN - 1)) begin
            do_abort = 1'b1;
            state_nx = REPORT;
          end
        end else begin
          do_abort = 1'b1;
          state_nx = REPORT;
        end
      end
      WAIT: begin
        if (wait_ph) state_nx = REPORT;
      end
      REPORT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (reset) begin
      s0_ready = 1'b0;
      s1_ready = 1'b0;
      xfer     = 1'b0;
      do_abort = 1'b0;
      start    = 1'b0;
    end
  end

  assign res_valid = (state == REPORT);
  assign res_src   = res_valid ? grant   : 1'b0;
  assign res_type  = res_valid ? type_r  : 2'd0;
  assign res_abort = res_valid ? abort_r : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= 1'b0;
      rr        <= 1'b0;
      len       <= '0;
      wait_ph   <= 1'b0;
      type_r    <= 2'd0;
      abort_r   <= 1'b0;
      chk_char  <= FILL;
      chk_reset <= 1'b1;
      cnt_reg   <= '0;
      cnt_mem   <= '0;
      cnt_bad   <= '0;
    end else begin
      chk_char  <= FILL;
      chk_reset <= 1'b0;
      if (start) begin
        grant   <= grant_nx;
        rr      <= !grant_nx;
        len     <= '0;
        wait_ph <= 1'b0;
        type_r  <= 2'd0;
        abort_r <= 1'b0;
      end
      if (xfer && !do_abort) begin
        chk_char <= cur_char;
        len      <= len + 1'b1;
      end
      if (do_abort) begin
        chk_reset <= 1'b1;
        abort_r   <= 1'b1;
        type_r    <= 2'd0;
      end
      // checker output for the '#' is valid on the second WAIT cycle
      if (state == WAIT) begin
        wait_ph <= 1'b1;
        if (wait_ph) type_r <= (chk_format == 2'd3) ? 2'd0 : chk_format;
      end
      if (state == REPORT) begin
        if (!abort_r && type_r == 2'd1) begin
          if (cnt_reg != {CNT_W{1'b1}}) cnt_reg <= cnt_reg + 1'b1;
        end else if (!abort_r && type_r == 2'd2) begin
          if (cnt_mem != {CNT_W{1'b1}}) cnt_mem <= cnt_mem + 1'b1;
        end else begin
          if (cnt_bad != {CNT_W{1'b1}}) cnt_bad <= cnt_bad + 1'b1;
        end
      end
    end
  end

endmodule
